spi_master_ctrl: RTL and testbench

//   SPI master that drives the SPI slave + single-port RAM subsystem from a parallel command port.

---
 rtl/spi_master_ctrl.sv | 138 +++++++++++++
 tb/tb_spi_master_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master: turns {cmd_type, cmd_data} requests into SS_n frames on MOSI.
// Read-data frames capture the 8-bit MISO reply and return it on rsp_data.
module spi_master_ctrl #(
   parameter int unsigned RD_LATENCY = 2,
   parameter int unsigned IDLE_GAP   = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_type,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       busy,
   output logic       MOSI,
   input  logic       MISO,
   output logic       SS_n
);

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_SHIFT, S_WAIT, S_READ, S_GAP
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [9:0] word_q, word_d;
   logic       ss_n_q, mosi_q, ready_q, busy_q;
   logic       rd_en_q, rsp_valid_q;
   logic [6:0] sh_q;
   logic [7:0] rsp_data_q;
   logic       accept, idle_d, rd_last;

   assign accept  = cmd_valid & ready_q;
   // ready only from the second IDLE cycle on, and drops on accept
   assign idle_d  = (state_q == S_IDLE) & ~accept;
   // last READ output cycle: the serial window lags the state by one
   assign rd_last = rd_en_q & (state_q != S_READ);

   // state, counter and latched frame word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         word_q  <= word_d;
      end
   end

   // next-state: phase sequencing and per-phase cycle counts
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      word_d  = word_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               word_d  = {cmd_type, cmd_data};
               state_d = S_SEL;
               cnt_d   = '0;
            end
         end
         S_SEL: begin
            state_d = S_SHIFT;
            cnt_d   = '0;
         end
         S_SHIFT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd9) begin
               cnt_d   = '0;
               state_d = (word_q[9:8] == 2'b11) ? S_WAIT : S_GAP;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(RD_LATENCY - 1)) begin
               cnt_d   = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
               cnt_d   = '0;
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'(IDLE_GAP - 1)) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // registered serial/handshake outputs and MISO capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_n_q      <= 1'b1;
         mosi_q      <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         rd_en_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         sh_q        <= '0;
         rsp_data_q  <= '0;
      end else begin
         ss_n_q      <= ~(state_q inside
                          {S_SEL, S_SHIFT, S_WAIT, S_READ});
         mosi_q      <= (state_q == S_SEL)   ? word_q[9] :
                        (state_q == S_SHIFT) ? word_q[4'd9 - cnt_q] :
                        1'b0;
         ready_q     <= idle_d;
         busy_q      <= ~idle_d;
         rd_en_q     <= (state_q == S_READ);
         rsp_valid_q <= rd_last;
         if (rd_en_q) sh_q <= {sh_q[5:0], MISO};
         if (rd_last) rsp_data_q <= {sh_q, MISO};
      end
   end

   assign cmd_ready = ready_q;
   assign busy      = busy_q;
   assign SS_n      = ss_n_q;
   assign MOSI      = mosi_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a behavioural SPI slave/RAM.
// A second instance covers the IDLE_GAP=3, RD_LATENCY=4 build.
module tb_spi_master_ctrl;

   localparam int RDL  = 2;
   localparam int RDL6 = 4;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       cmd_valid, cmd_ready;
   logic [1:0] cmd_type;
   logic [7:0] cmd_data;
   logic       rsp_valid, busy, MOSI, SS_n;
   logic       MISO = 1'b0;
   logic [7:0] rsp_data;

   logic       v6, rdy6, rv6, busy6, mosi6, ss6;
   logic       miso6 = 1'b0;
   logic [1:0] t6;
   logic [7:0] d6, rd6;

   spi_master_ctrl u_dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .busy(busy), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
   );

   spi_master_ctrl #(.RD_LATENCY(RDL6), .IDLE_GAP(3)) u_dut6 (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(v6), .cmd_ready(rdy6),
      .cmd_type(t6), .cmd_data(d6),
      .rsp_valid(rv6), .rsp_data(rd6),
      .busy(busy6), .MOSI(mosi6), .MISO(miso6), .SS_n(ss6)
   );

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // slave model: frame decode, RAM, MISO reply, SS_n/gap timing
   int         k = 0, last_low = 0, gcnt = 0, last_gap = 0;
   int         rsp_cnt = 0;
   logic [9:0] sh = '0;
   logic [10:0] mos = '0;
   logic [7:0] mem [256];
   logic [7:0] wa = '0, ra = '0, rbyte = '0;
   logic [9:0] rx [$];

   always @(negedge clk) begin
      if (rsp_valid) rsp_cnt++;
      if (SS_n) begin
         if (k > 0) last_low = k;
         k = 0;
         if (busy) gcnt++;
         else begin
            if (gcnt > 0) last_gap = gcnt;
            gcnt = 0;
         end
      end else begin
         gcnt = 0;
         k++;
         mos = {mos[9:0], MOSI};
         if (k >= 2 && k <= 11) sh = {sh[8:0], MOSI};
         if (k == 11) begin
            rx.push_back(sh);
            case (sh[9:8])
               2'b00: wa = sh[7:0];
               2'b01: mem[wa] = sh[7:0];
               2'b10: ra = sh[7:0];
               default: rbyte = mem[ra];
            endcase
         end
      end
      if (!SS_n && k >= 12 + RDL && k <= 19 + RDL)
         MISO = rbyte[19 + RDL - k];
      else
         MISO = 1'b0;
   end

   int k6 = 0, last_low6 = 0, gcnt6 = 0, last_gap6 = 0;
   int rsp_cnt6 = 0;
   logic [7:0] rbyte6 = 8'h96;

   always @(negedge clk) begin
      if (rv6) rsp_cnt6++;
      if (ss6) begin
         if (k6 > 0) last_low6 = k6;
         k6 = 0;
         if (busy6) gcnt6++;
         else begin
            if (gcnt6 > 0) last_gap6 = gcnt6;
            gcnt6 = 0;
         end
      end else begin
         gcnt6 = 0;
         k6++;
      end
      if (!ss6 && k6 >= 12 + RDL6 && k6 <= 19 + RDL6)
         miso6 = rbyte6[19 + RDL6 - k6];
      else
         miso6 = 1'b0;
   end

   task automatic send(input logic [1:0] t, input logic [7:0] d,
                       output int acc);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_type  = t;
      cmd_data  = d;
      while (!cmd_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) check("send_timeout", 32'(cmd_ready), 32'd1);
      acc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("idle_timeout", 32'(cmd_ready), 32'd1);
      #1;
   endtask

   int a1, a2, dmy, na, n;
   logic [9:0] ex [$];

   initial begin
      rst_n = 1'b0;
      cmd_valid = 1'b0; cmd_type = '0; cmd_data = '0;
      v6 = 1'b0; t6 = '0; d6 = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst_ss_n", 32'(SS_n), 32'd1);
      check("rst_mosi", 32'(MOSI), 32'd0);
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_data", 32'(rsp_data), 32'h00);

      // reset in the middle of a read frame
      @(negedge clk);
      send(2'b11, 8'h00, dmy);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_ss_n", 32'(SS_n), 32'd1);
      check("mid_rst_ready", 32'(cmd_ready), 32'd1);
      check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("mid_rst_no_rsp", 32'(rsp_cnt), 32'd0);

      // wr-addr A5: bit pattern, SS_n window, gap, accept spacing
      send(2'b00, 8'hA5, a1);
      wait_idle();
      check("wa_mosi_bits", 32'(mos), 32'(11'b000_1010_0101));
      check("wa_ss_low", 32'(last_low), 32'd11);
      check("wa_gap", 32'(last_gap), 32'd1);
      send(2'b00, 8'h3C, a2);
      check("accept_spacing", 32'(a2 - a1), 32'd14);

      // end-to-end write then read of 0x3C
      send(2'b01, 8'h5A, dmy);
      send(2'b10, 8'h3C, dmy);
      wait_idle();
      check("no_rsp_on_writes", 32'(rsp_cnt), 32'd0);
      send(2'b11, 8'hFF, dmy);
      wait_idle();
      check("e2e_rsp_count", 32'(rsp_cnt), 32'd1);
      check("e2e_rsp_data", 32'(rsp_data), 32'h5A);

      // second read returning C3, SS_n length of a read frame
      send(2'b00, 8'h10, dmy);
      send(2'b01, 8'hC3, dmy);
      send(2'b10, 8'h10, dmy);
      send(2'b11, 8'h00, dmy);
      wait_idle();
      check("rd_rsp_data", 32'(rsp_data), 32'hC3);
      check("rd_rsp_count", 32'(rsp_cnt), 32'd2);
      check("rd_ss_low", 32'(last_low), 32'd21);

      // cmd_valid held high with data changing every cycle
      rx.delete();
      na = 0;
      n = 0;
      cmd_valid = 1'b1;
      cmd_type  = 2'b01;
      while (na < 3 && n < 200) begin
         cmd_data = 8'h40 + n[7:0];
         if (cmd_ready) begin
            ex.push_back({2'b01, cmd_data});
            na++;
         end
         @(negedge clk);
         n++;
      end
      cmd_valid = 1'b0;
      wait_idle();
      check("held_frames", 32'(rx.size()), 32'd3);
      for (int i = 0; i < 3; i++)
         if (i < rx.size() && i < ex.size())
            check($sformatf("held_frame%0d", i),
                  32'(rx[i]), 32'(ex[i]));

      // IDLE_GAP=3, RD_LATENCY=4 instance
      @(negedge clk);
      v6 = 1'b1; t6 = 2'b11; d6 = 8'h00;
      @(negedge clk);
      v6 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!rdy6 && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("p6_timeout", 32'(rdy6), 32'd1);
      #1;
      check("p6_rsp_data", 32'(rd6), 32'h96);
      check("p6_rsp_count", 32'(rsp_cnt6), 32'd1);
      check("p6_ss_low", 32'(last_low6), 32'd23);
      check("p6_gap", 32'(last_gap6), 32'd3);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
